btn_write_strobe: RTL and testbench
===================================

Name: btn_write_strobe

Overview:
- Upstream conditioning stage for the 4-bank 8-bit latch store.
- Synchronises the raw push-button and the bank-select/data switches to the system clock, and debounces the button.
- On each confirmed press, emits exactly one single-cycle write strobe, together with a bank select and data byte held stable. These drive the bank demultiplexers in place of the raw button.
- Also provides a debounced button level and a wrapping press counter for status display.

Parameters:
- DEBOUNCE_CYCLES, 1000000, consecutive stable synchronised samples needed to accept a press or a release (10 ms at 100 MHz). Legal range is at least 2.
- CNT_W, 20, width of the debounce counter. Must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- clk  input  1  system clock; all state changes on its rising edge
- rst_n  input  1  asynchronous active-low reset
- btn_raw  input  1  raw, bouncing push-button
- sel_raw  input  2  raw bank-select switches
- data_raw  input  8  raw data switches
- wr_en  output  1  single-cycle write strobe, one per accepted press
- wr_sel  output  2  bank select captured at the strobe; stable until the next strobe
- wr_data  output  8  data captured at the strobe; stable until the next strobe
- btn_level  output  1  debounced button level: 1 in PRESSED and RELEASE_WAIT, else 0
- busy  output  1  1 whenever the state is not IDLE
- press_count  output  8  number of accepted presses, modulo 256

Behaviour:
- Reset (async, rst_n=0):
  - synchroniser flops, counter, state=IDLE, wr_en, wr_sel, wr_data, btn_level, busy and press_count all go to 0 immediately.
- Synchronisers:
  - btn_raw, sel_raw and data_raw each pass through a 2-flop synchroniser, giving btn_s, sel_s and data_s.
  - A raw change set up before edge k appears on the synchronised signal after edge k+1.
- FSM states: IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT.
  - IDLE: if btn_s=1, go to PRESS_WAIT with cnt=1; otherwise stay with cnt=0.
  - PRESS_WAIT, btn_s=0: return to IDLE with cnt=0. This is a bounce: no strobe, no capture.
  - PRESS_WAIT, btn_s=1 and cnt==DEBOUNCE_CYCLES-1: go to PRESSED and assert wr_en on that edge. On the same edge, wr_sel<=sel_s, wr_data<=data_s and press_count<=press_count+1. Set cnt=0.
  - PRESS_WAIT, btn_s=1 otherwise: cnt<=cnt+1.
  - PRESSED: if btn_s=0, go to RELEASE_WAIT with cnt=1; otherwise stay.
  - RELEASE_WAIT, btn_s=1: return to PRESSED with cnt=0. This is release bounce: no new strobe.
  - RELEASE_WAIT, btn_s=0 and cnt==DEBOUNCE_CYCLES-1: go to IDLE with cnt=0.
  - RELEASE_WAIT, btn_s=0 otherwise: cnt<=cnt+1.
- Strobe timing:
  - wr_en is registered and high for exactly one cycle, after the edge at which btn_s has been sampled 1 on DEBOUNCE_CYCLES consecutive edges.
  - For a clean raw step set up before edge 1, wr_en is high in the cycle after edge DEBOUNCE_CYCLES+2.
- Output stability:
  - wr_sel and wr_data change only on the strobe edge.
  - They are valid in the same cycle wr_en is high and hold afterwards, regardless of later switch movement.
- One write per press: holding the button indefinitely yields exactly one strobe. Another strobe requires a full debounced release followed by a full debounced press.
- press_count wraps from 255 to 0. wr_en still pulses normally on the wrap.
- Switch changes during PRESS_WAIT: the value captured is whatever sel_s and data_s hold on the strobe edge.
- Reset mid-operation:
  - Any state aborts to IDLE and no strobe is generated while rst_n=0.
  - If the button is still held when rst_n deasserts, it is treated as a new press: one strobe follows after a full synchroniser plus debounce delay.
- busy is combinational from state. btn_level is decoded from state. No combinational path from any raw input to any output.

Test Plan (DEBOUNCE_CYCLES=4):
1. Reset, then btn_raw=1 before edge 1 with sel_raw=2, data_raw=0xA5 -> wr_en=1 only in the cycle after edge 6, with wr_sel=2, wr_data=0xA5, press_count=1 and btn_level=1 from that cycle.
2. Bounce: btn_raw high for 3 cycles, low for 1, then high and held -> exactly one wr_en, 4 clean btn_s samples after the last rising edge; press_count=1.
3. Hold the button for 100 cycles, then release with a 2-cycle bounce, then press again cleanly -> exactly 2 wr_en pulses in total. btn_level stays 1 through the release bounce and returns to 0 only after 4 stable low samples.
4. Set sel_raw=1 and data_raw=0x3C at press, then change them to 3 and 0xFF after the strobe -> wr_sel=1 and wr_data=0x3C held until the next strobe.
5. 256 clean presses -> press_count reads 0 after the 256th strobe; wr_en pulses on every press.
6. Assert rst_n=0 during PRESS_WAIT (cnt=2) while the button is held, release reset after 3 cycles -> all outputs 0 immediately, no strobe during reset, then one wr_en in the cycle after the 6th edge following rst_n deassertion.

Source files
------------

// File: rtl/btn_write_strobe_if.sv
// btn_write_strobe_if: raw switch inputs and conditioned write-strobe outputs
interface btn_write_strobe_if;
    logic       btn_raw;
    logic [1:0] sel_raw;
    logic [7:0] data_raw;
    logic       wr_en;
    logic [1:0] wr_sel;
    logic [7:0] wr_data;
    logic       btn_level;
    logic       busy;
    logic [7:0] press_count;
    modport master (
        input  btn_raw, sel_raw, data_raw,
        output wr_en, wr_sel, wr_data, btn_level, busy, press_count
    );
    modport slave (
        output btn_raw, sel_raw, data_raw,
        input  wr_en, wr_sel, wr_data, btn_level, busy, press_count
    );
endinterface

// File: rtl/btn_write_strobe.sv
// btn_write_strobe: synchronise and debounce a push-button, emit one write strobe per press
module btn_write_strobe #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W = 20
) (
    input logic                clk,
    input logic                rst_n,
    btn_write_strobe_if.master bus
);
    typedef enum logic [1:0] {IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT} state_t;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             btn_m, btn_s;
    logic [1:0]       sel_m, sel_s;
    logic [7:0]       data_m, data_s;
    assign bus.busy      = state != IDLE;
    assign bus.btn_level = state == PRESSED || state == RELEASE_WAIT;
    // two-flop synchronisers for every raw input
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {btn_m, btn_s}   <= '0;
            {sel_m, sel_s}   <= '0;
            {data_m, data_s} <= '0;
        end else begin
            {btn_m, btn_s}   <= {bus.btn_raw, btn_m};
            {sel_m, sel_s}   <= {bus.sel_raw, sel_m};
            {data_m, data_s} <= {bus.data_raw, data_m};
        end
    end
    // debounce FSM; strobe and capture happen on the edge the press is confirmed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            cnt             <= '0;
            bus.wr_en       <= 1'b0;
            bus.wr_sel      <= '0;
            bus.wr_data     <= '0;
            bus.press_count <= '0;
        end else begin
            bus.wr_en <= 1'b0;
            case (state)
                IDLE: begin
                    state <= btn_s ? PRESS_WAIT : IDLE;
                    cnt   <= btn_s ? CNT_W'(1) : '0;
                end
                PRESS_WAIT: begin
                    if (!btn_s) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (cnt == LAST) begin
                        state           <= PRESSED;
                        cnt             <= '0;
                        bus.wr_en       <= 1'b1;
                        bus.wr_sel      <= sel_s;
                        bus.wr_data     <= data_s;
                        bus.press_count <= bus.press_count + 8'd1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                PRESSED: begin
                    if (!btn_s) begin
                        state <= RELEASE_WAIT;
                        cnt   <= CNT_W'(1);
                    end
                end
                RELEASE_WAIT: begin
                    if (btn_s) begin
                        state <= PRESSED;
                        cnt   <= '0;
                    end else if (cnt == LAST) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_btn_write_strobe.sv
// tb_btn_write_strobe: directed checks of debounce, strobe timing, capture, wrap and reset
module tb_btn_write_strobe;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   pulses = 0;
    int   p0;
    btn_write_strobe_if bus ();
    btn_write_strobe #(.DEBOUNCE_CYCLES(4), .CNT_W(3)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.master)
    );
    always #5 clk = ~clk;
    // count every cycle in which the strobe is high
    always @(posedge clk) begin
        #1;
        if (bus.wr_en) pulses++;
    end
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    initial begin
        bus.btn_raw = 1'b0;
        bus.sel_raw = 2'd0;
        bus.data_raw = 8'h00;
        #1;
        chk("rst_wr_en", 32'(bus.wr_en), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_level", 32'(bus.btn_level), 0);
        chk("rst_count", 32'(bus.press_count), 0);
        chk("rst_sel", 32'(bus.wr_sel), 0);
        chk("rst_data", 32'(bus.wr_data), 0);
        tick(2);
        // clean press
        rst_n = 1'b1;
        bus.btn_raw = 1'b1;
        bus.sel_raw = 2'd2;
        bus.data_raw = 8'hA5;
        tick(5);
        chk("t1_e5_wr_en", 32'(bus.wr_en), 0);
        chk("t1_e5_busy", 32'(bus.busy), 1);
        chk("t1_e5_level", 32'(bus.btn_level), 0);
        tick(1);
        chk("t1_e6_wr_en", 32'(bus.wr_en), 1);
        chk("t1_e6_sel", 32'(bus.wr_sel), 2);
        chk("t1_e6_data", 32'(bus.wr_data), 32'hA5);
        chk("t1_e6_count", 32'(bus.press_count), 1);
        chk("t1_e6_level", 32'(bus.btn_level), 1);
        tick(1);
        chk("t1_e7_wr_en", 32'(bus.wr_en), 0);
        chk("t1_e7_count", 32'(bus.press_count), 1);
        // clean release: level drops after four stable low samples
        bus.btn_raw = 1'b0;
        tick(5);
        chk("t1_rel_e5_level", 32'(bus.btn_level), 1);
        tick(1);
        chk("t1_rel_e6_level", 32'(bus.btn_level), 0);
        chk("t1_rel_e6_busy", 32'(bus.busy), 0);
        // press bounce: high 3, low 1, then held
        p0 = pulses;
        bus.btn_raw = 1'b1;
        tick(3);
        bus.btn_raw = 1'b0;
        tick(1);
        bus.btn_raw = 1'b1;
        tick(2);
        chk("t2_e6_busy", 32'(bus.busy), 0);
        tick(3);
        chk("t2_e9_wr_en", 32'(bus.wr_en), 0);
        chk("t2_e9_busy", 32'(bus.busy), 1);
        tick(1);
        chk("t2_e10_wr_en", 32'(bus.wr_en), 1);
        chk("t2_e10_count", 32'(bus.press_count), 2);
        tick(5);
        chk("t2_pulses", 32'(pulses - p0), 1);
        // long hold then release bounce
        p0 = pulses;
        tick(100);
        chk("t3_hold_level", 32'(bus.btn_level), 1);
        chk("t3_hold_pulses", 32'(pulses - p0), 0);
        bus.btn_raw = 1'b0;
        tick(2);
        bus.btn_raw = 1'b1;
        tick(1);
        bus.btn_raw = 1'b0;
        tick(1);
        chk("t3_e4_level", 32'(bus.btn_level), 1);
        tick(4);
        chk("t3_e8_level", 32'(bus.btn_level), 1);
        tick(1);
        chk("t3_e9_level", 32'(bus.btn_level), 0);
        chk("t3_e9_busy", 32'(bus.busy), 0);
        chk("t3_bounce_pulses", 32'(pulses - p0), 0);
        // capture then move switches
        bus.sel_raw = 2'd1;
        bus.data_raw = 8'h3C;
        bus.btn_raw = 1'b1;
        tick(6);
        chk("t4_wr_en", 32'(bus.wr_en), 1);
        chk("t4_sel", 32'(bus.wr_sel), 1);
        chk("t4_data", 32'(bus.wr_data), 32'h3C);
        chk("t4_count", 32'(bus.press_count), 3);
        bus.sel_raw = 2'd3;
        bus.data_raw = 8'hFF;
        tick(10);
        chk("t4_hold_sel", 32'(bus.wr_sel), 1);
        chk("t4_hold_data", 32'(bus.wr_data), 32'h3C);
        chk("t4_hold_wr_en", 32'(bus.wr_en), 0);
        chk("t4_total_pulses", 32'(pulses), 3);
        // many presses up to the counter wrap
        bus.btn_raw = 1'b0;
        tick(6);
        bus.sel_raw = 2'd2;
        bus.data_raw = 8'h5A;
        p0 = pulses;
        for (int i = 0; i < 252; i++) begin
            bus.btn_raw = 1'b1;
            tick(6);
            bus.btn_raw = 1'b0;
            tick(6);
        end
        chk("t5_count_255", 32'(bus.press_count), 255);
        bus.btn_raw = 1'b1;
        tick(6);
        chk("t5_wrap_wr_en", 32'(bus.wr_en), 1);
        chk("t5_wrap_count", 32'(bus.press_count), 0);
        chk("t5_pulses", 32'(pulses - p0), 253);
        // reset during press debounce with the button held
        bus.btn_raw = 1'b0;
        tick(6);
        bus.btn_raw = 1'b1;
        tick(4);
        chk("t6_pre_busy", 32'(bus.busy), 1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_wr_en", 32'(bus.wr_en), 0);
        chk("t6_rst_busy", 32'(bus.busy), 0);
        chk("t6_rst_level", 32'(bus.btn_level), 0);
        chk("t6_rst_count", 32'(bus.press_count), 0);
        chk("t6_rst_sel", 32'(bus.wr_sel), 0);
        chk("t6_rst_data", 32'(bus.wr_data), 0);
        p0 = pulses;
        tick(3);
        chk("t6_rst_pulses", 32'(pulses - p0), 0);
        chk("t6_rst_busy_hold", 32'(bus.busy), 0);
        rst_n = 1'b1;
        tick(5);
        chk("t6_e5_wr_en", 32'(bus.wr_en), 0);
        chk("t6_e5_busy", 32'(bus.busy), 1);
        tick(1);
        chk("t6_e6_wr_en", 32'(bus.wr_en), 1);
        chk("t6_e6_count", 32'(bus.press_count), 1);
        chk("t6_e6_sel", 32'(bus.wr_sel), 2);
        chk("t6_e6_data", 32'(bus.wr_data), 32'h5A);
        tick(1);
        chk("t6_e7_wr_en", 32'(bus.wr_en), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
